// File: rtl/shift_operand_stage.sv
// shift_operand_stage
// Operand-2 decode stage feeding the barrel shifter. Accepts one ARM
// data-processing instruction per valid/ready handshake, reads the register
// file through a single combinational read port, and presents registered
// shifter controls and operands.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous flush; drops any in-flight work
//   in_valid/in_ready instruction handshake
//   instr[31:0]       instruction word
//   rf_addr[3:0]      register file read index (combinational)
//   rf_data[31:0]     register file read data (same cycle as rf_addr)
//   out_valid/out_ready result handshake
//   vimm              1: use valimm, 0: use valreg
//   bimm              1: use byimm,  0: use byreg
//   shift_type[1:0]   LSL=00, LSR=01, ASR=10, ROR=11
//   rrx               ROR #0 encoding (rotate right extended)
//   valimm[31:0]      zero-extended imm8
//   valreg[31:0]      value of Rm
//   byimm[31:0]       immediate shift amount
//   byreg[31:0]       Rs[7:0] zero-extended
module shift_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        vimm,
  output logic        bimm,
  output logic [1:0]  shift_type,
  output logic        rrx,
  output logic [31:0] valimm,
  output logic [31:0] valreg,
  output logic [31:0] byimm,
  output logic [31:0] byreg
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    FETCH_RS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic        vimm_q, vimm_d;
  logic        bimm_q, bimm_d;
  logic [1:0]  type_q, type_d;
  logic        rrx_q, rrx_d;
  logic [31:0] valimm_q, valimm_d;
  logic [31:0] valreg_q, valreg_d;
  logic [31:0] byimm_q, byimm_d;
  logic [31:0] byreg_q, byreg_d;
  logic [3:0]  rs_q, rs_d;

  logic        accept;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_type;

  // Instruction bits that do not affect operand-2 decode.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[24:12]};

  assign sh_amt  = instr[11:7];
  assign sh_type = instr[6:5];

  // in_ready depends only on state, flush and out_ready, never on in_valid.
  assign in_ready = (state_q == IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign rf_addr  = (state_q == FETCH_RS) ? rs_q : instr[3:0];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    vimm_d      = vimm_q;
    bimm_d      = bimm_q;
    type_d      = type_q;
    rrx_d       = rrx_q;
    valimm_d    = valimm_q;
    valreg_d    = valreg_q;
    byimm_d     = byimm_q;
    byreg_d     = byreg_q;
    rs_d        = rs_q;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (instr[25]) begin
              // Rotated immediate: imm8 rotated right by 2*rot4.
              out_valid_d = 1'b1;
              vimm_d      = 1'b1;
              bimm_d      = 1'b1;
              type_d      = 2'b11;
              rrx_d       = 1'b0;
              valimm_d    = {24'b0, instr[7:0]};
              valreg_d    = '0;
              byimm_d     = {27'b0, instr[11:8], 1'b0};
              byreg_d     = '0;
            end else if (!instr[4]) begin
              // Immediate shift; a zero amount re-encodes LSR/ASR #32 and RRX.
              out_valid_d = 1'b1;
              vimm_d      = 1'b0;
              bimm_d      = 1'b1;
              type_d      = sh_type;
              rrx_d       = (sh_amt == 5'd0) && (sh_type == 2'b11);
              valimm_d    = '0;
              valreg_d    = rf_data;
              byreg_d     = '0;
              if ((sh_amt == 5'd0) && (sh_type == 2'b01 || sh_type == 2'b10))
                byimm_d = 32'd32;
              else
                byimm_d = {27'b0, sh_amt};
            end else begin
              // Register shift: capture Rm now, read Rs next cycle.
              out_valid_d = 1'b0;
              state_d     = FETCH_RS;
              rs_d        = instr[11:8];
              vimm_d      = 1'b0;
              bimm_d      = 1'b0;
              type_d      = sh_type;
              rrx_d       = 1'b0;
              valimm_d    = '0;
              valreg_d    = rf_data;
              byimm_d     = '0;
              byreg_d     = '0;
            end
          end else if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        FETCH_RS: begin
          byreg_d     = {24'b0, rf_data[7:0]};
          vimm_d      = 1'b0;
          bimm_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      vimm_q      <= 1'b0;
      bimm_q      <= 1'b0;
      type_q      <= 2'b00;
      rrx_q       <= 1'b0;
      valimm_q    <= '0;
      valreg_q    <= '0;
      byimm_q     <= '0;
      byreg_q     <= '0;
      rs_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      vimm_q      <= vimm_d;
      bimm_q      <= bimm_d;
      type_q      <= type_d;
      rrx_q       <= rrx_d;
      valimm_q    <= valimm_d;
      valreg_q    <= valreg_d;
      byimm_q     <= byimm_d;
      byreg_q     <= byreg_d;
      rs_q        <= rs_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign vimm       = vimm_q;
  assign bimm       = bimm_q;
  assign shift_type = type_q;
  assign rrx        = rrx_q;
  assign valimm     = valimm_q;
  assign valreg     = valreg_q;
  assign byimm      = byimm_q;
  assign byreg      = byreg_q;

endmodule
